// File: rtl/instr_fetch_unit.sv
// Instruction-fetch client of the shared memory arbiter: one outstanding read,
// prefetch FIFO toward decode, redirect flushes the FIFO and retargets fetch.
module instr_fetch_unit #(
   parameter int unsigned        M_WIDTH    = 32,
   parameter int unsigned        FIFO_DEPTH = 4,
   parameter logic [M_WIDTH-1:0] RESET_PC   = '0,
   parameter logic [1:0]         MEM_ACC_32 = 2'b10
) (
   input  logic               clk,
   input  logic               rst,
   output logic               mem_req,
   output logic [M_WIDTH-1:0] mem_addr,
   output logic               mem_we,
   output logic [1:0]         mem_width,
   output logic [M_WIDTH-1:0] mem_data_out,
   input  logic [M_WIDTH-1:0] mem_data_in,
   input  logic               mem_ready,
   input  logic               redirect,
   input  logic [M_WIDTH-1:0] redirect_pc,
   output logic               instr_valid,
   output logic [M_WIDTH-1:0] instr_data,
   output logic [M_WIDTH-1:0] instr_pc,
   input  logic               instr_ready
);

   localparam int unsigned PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
   localparam int unsigned CNT_W = $clog2(FIFO_DEPTH + 1);
   localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(FIFO_DEPTH);

   typedef enum logic [1:0] {IDLE, REQ, REL} state_t;

   state_t             state, state_nxt;
   logic               issue;
   logic               capture;
   logic               push;
   logic               pop;
   logic               drop;
   logic               can_issue;
   logic [M_WIDTH-1:0] fetch_pc;
   logic [PTR_W-1:0]   wr_ptr, rd_ptr;
   logic [CNT_W-1:0]   count;
   logic [M_WIDTH-1:0] data_mem [FIFO_DEPTH];
   logic [M_WIDTH-1:0] pc_mem   [FIFO_DEPTH];

   assign mem_we       = 1'b0;
   assign mem_width    = MEM_ACC_32;
   assign mem_data_out = '0;

   assign can_issue   = (count < DEPTH_C);
   assign capture     = (state == REQ) && mem_ready;
   assign push        = capture && !drop && !redirect;
   assign instr_valid = (count != '0);
   assign pop         = instr_valid && instr_ready && !redirect;
   assign instr_data  = data_mem[rd_ptr];
   assign instr_pc    = pc_mem[rd_ptr];

   always_ff @(posedge clk) begin
      if (rst) state <= IDLE;
      else     state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      issue     = 1'b0;
      case (state)
         IDLE: begin
            if (can_issue) begin
               issue     = 1'b1;
               state_nxt = REQ;
            end
         end
         REQ: begin
            if (mem_ready) state_nxt = REL;
         end
         REL: begin
            if (can_issue) begin
               issue     = 1'b1;
               state_nxt = REQ;
            end else begin
               state_nxt = IDLE;
            end
         end
         default: state_nxt = IDLE;
      endcase
   end

   // A redirect coinciding with an issue targets the new PC directly, so the
   // stale fetch_pc is never requested.
   always_ff @(posedge clk) begin
      if (rst) begin
         mem_req  <= 1'b0;
         mem_addr <= RESET_PC;
      end else if (issue) begin
         mem_req  <= 1'b1;
         mem_addr <= redirect ? redirect_pc : fetch_pc;
      end else if (capture) begin
         mem_req  <= 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         fetch_pc <= RESET_PC;
         drop     <= 1'b0;
      end else begin
         if (redirect)  fetch_pc <= redirect_pc;
         else if (push) fetch_pc <= mem_addr + M_WIDTH'(4);
         // The in-flight read cannot be aborted, so its data is marked stale.
         if (capture)                       drop <= 1'b0;
         else if (redirect && state == REQ) drop <= 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else if (redirect) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (push) wr_ptr <= wr_ptr + 1'b1;
         if (pop)  rd_ptr <= rd_ptr + 1'b1;
         case ({push, pop})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (push) begin
         data_mem[wr_ptr] <= mem_data_in;
         pc_mem[wr_ptr]   <= mem_addr;
      end
   end

endmodule
